barrel_shifter_pipe: RTL and testbench

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

---
 rtl/barrel_shifter_pipe_if.sv | 28 ++
 rtl/barrel_shifter_pipe.sv | 91 +++++++++
 tb/tb_barrel_shifter_pipe.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/barrel_shifter_pipe_if.sv
// Valid/ready stream bundle for the pipelined barrel shifter.
// The master side drives operands and consumes results.
interface barrel_shifter_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int SW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [SW-1:0]    smt;
    logic [2:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             carry_out;
    logic             mode_err;

    modport slave (
        input  in_valid, data_in, smt, mode, out_ready,
        output in_ready, out_valid, data_out, carry_out, mode_err
    );

    modport master (
        output in_valid, data_in, smt, mode, out_ready,
        input  in_ready, out_valid, data_out, carry_out, mode_err
    );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Log-depth pipelined barrel shifter: stage k shifts by 2^k.
// Whole pipe advances in lockstep; a stalled output freezes every stage.
module barrel_shifter_pipe #(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    barrel_shifter_pipe_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [SW-1:0]    smt;
        logic [2:0]       mode;
        logic             carry;
    } stage_t;

    stage_t [SW-1:0] st_q;
    stage_t [SW-1:0] st_d;
    stage_t          in_beat;
    stage_t          prev;
    logic            advance;

    // Carry tracks the last bit to leave; for rotates it is the bit
    // that wrapped, which later non-shifting stages leave in place.
    function automatic stage_t shift_stage(input stage_t s, input int k);
        stage_t r;
        int     sh;
        r  = s;
        sh = 1 << k;
        if (((s.smt >> k) & SW'(1)) != '0) begin
            case (s.mode)
                3'b000, 3'b010: begin
                    r.data  = s.data << sh;
                    r.carry = |(s.data & (WIDTH'(1) << (WIDTH - sh)));
                end
                3'b001: begin
                    r.data  = s.data >> sh;
                    r.carry = |(s.data & (WIDTH'(1) << (sh - 1)));
                end
                3'b011: begin
                    r.data  = $signed(s.data) >>> sh;
                    r.carry = |(s.data & (WIDTH'(1) << (sh - 1)));
                end
                3'b100: begin
                    r.data  = (s.data << sh) | (s.data >> (WIDTH - sh));
                    r.carry = r.data[0];
                end
                3'b101: begin
                    r.data  = (s.data >> sh) | (s.data << (WIDTH - sh));
                    r.carry = r.data[WIDTH-1];
                end
                default: r = s;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        advance       = !st_q[SW-1].valid || bus.out_ready;
        in_beat       = '0;
        in_beat.valid = bus.in_valid;
        in_beat.data  = bus.data_in;
        in_beat.smt   = bus.smt;
        in_beat.mode  = bus.mode;
        prev          = in_beat;
        st_d          = st_q;
        for (int k = 0; k < SW; k++) begin
            if (advance) begin
                st_d[k] = shift_stage(prev, k);
            end
            prev = st_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = st_q[SW-1].valid;
    assign bus.data_out  = st_q[SW-1].data;
    assign bus.carry_out = st_q[SW-1].carry;
    assign bus.mode_err  = &st_q[SW-1].mode[2:1];
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe at WIDTH=8: directed vectors, backpressure,
// reset flush and a randomized stream against a queue-based model.
module tb_barrel_shifter_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_out = 0;

    logic [7:0] exp_d[$];
    logic       exp_c[$];
    logic       exp_e[$];
    logic [7:0] obs_q[$];

    barrel_shifter_pipe_if #(.WIDTH(8)) b();

    barrel_shifter_pipe #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result from the shift rules, using wide arithmetic and bit loops.
    function automatic logic [9:0] model(input logic [7:0] d,
                                         input logic [2:0] n,
                                         input logic [2:0] m);
        logic [15:0] w;
        logic [7:0]  r;
        logic        c;
        logic        e;
        r = d;
        c = 1'b0;
        e = 1'b0;
        w = '0;
        case (m)
            3'd0, 3'd2: begin
                w = {8'h00, d} << n;
                r = w[7:0];
                c = (n != 0) && w[8];
            end
            3'd1: begin
                w = {d, 8'h00} >> n;
                r = w[15:8];
                c = (n != 0) && w[7];
            end
            3'd3: begin
                w = $signed({d, 8'h00}) >>> n;
                r = w[15:8];
                c = (n != 0) && w[7];
            end
            3'd4: begin
                for (int i = 0; i < int'(n); i++) r = {r[6:0], r[7]};
                c = (n != 0) && r[0];
            end
            3'd5: begin
                for (int i = 0; i < int'(n); i++) r = {r[0], r[7:1]};
                c = (n != 0) && r[7];
            end
            default: e = 1'b1;
        endcase
        return {e, c, r};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_d.delete();
            exp_c.delete();
            exp_e.delete();
        end else begin
            chk(32'(b.in_ready), 32'(!b.out_valid || b.out_ready), "in_ready_rule");
            if (b.out_valid && b.out_ready) begin
                n_out++;
                obs_q.push_back(b.data_out);
                if (exp_d.size() == 0) begin
                    chk(32'(1), 32'(0), "unexpected_beat");
                end else begin
                    chk({b.mode_err, b.carry_out, b.data_out},
                        {exp_e.pop_front(), exp_c.pop_front(), exp_d.pop_front()},
                        "stream_result");
                end
            end
            if (b.in_valid && b.in_ready) begin
                logic [9:0] r;
                r = model(b.data_in, b.smt, b.mode);
                exp_d.push_back(r[7:0]);
                exp_c.push_back(r[8]);
                exp_e.push_back(r[9]);
            end
        end
    end

    task automatic send_check(input logic [2:0] m, input logic [7:0] d,
                              input logic [2:0] s, input logic [7:0] ed,
                              input logic ec, input logic ee,
                              input string tag);
        int lat;
        b.out_ready = 1'b1;
        b.in_valid  = 1'b1;
        b.data_in   = d;
        b.smt       = s;
        b.mode      = m;
        @(posedge clk); #1;
        b.in_valid = 1'b0;
        lat = 1;
        while (!b.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(32'(lat), 32'd3, {tag, "_latency"});
        chk(32'(b.data_out), 32'(ed), {tag, "_data"});
        chk(32'(b.carry_out), 32'(ec), {tag, "_carry"});
        chk(32'(b.mode_err), 32'(ee), {tag, "_mode_err"});
        @(posedge clk); #1;
    endtask

    initial begin
        int idx;
        int stall;
        bit seen;
        bit acc;
        int n0;

        b.in_valid  = 1'b0;
        b.data_in   = '0;
        b.smt       = '0;
        b.mode      = '0;
        b.out_ready = 1'b0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk(32'(b.out_valid), 32'd0, "reset_out_valid");
        chk(32'(b.in_ready), 32'd1, "reset_in_ready");
        chk(32'(b.data_out), 32'd0, "reset_data_out");
        chk(32'(b.carry_out), 32'd0, "reset_carry_out");
        chk(32'(b.mode_err), 32'd0, "reset_mode_err");
        rst = 1'b0;
        @(posedge clk); #1;

        send_check(3'd0, 8'h96, 3'd3, 8'hB0, 1'b0, 1'b0, "lsl_96_3");
        send_check(3'd3, 8'h96, 3'd2, 8'hE5, 1'b1, 1'b0, "asr_96_2");
        send_check(3'd1, 8'h96, 3'd2, 8'h25, 1'b1, 1'b0, "lsr_96_2");
        send_check(3'd5, 8'h96, 3'd4, 8'h69, 1'b0, 1'b0, "ror_96_4");
        send_check(3'd4, 8'h81, 3'd1, 8'h03, 1'b1, 1'b0, "rol_81_1");
        send_check(3'd2, 8'h96, 3'd7, 8'h00, 1'b1, 1'b0, "asl_96_7");
        for (int m = 0; m < 6; m++)
            send_check(3'(m), 8'hA7, 3'd0, 8'hA7, 1'b0, 1'b0, "smt0");
        send_check(3'd6, 8'h5A, 3'd5, 8'h5A, 1'b0, 1'b1, "reserved_110");
        send_check(3'd0, 8'h5A, 3'd1, 8'hB4, 1'b0, 1'b0, "after_reserved");

        // Backpressure: six LSL-by-1 beats, five stalled cycles.
        obs_q.delete();
        n0    = n_out;
        idx   = 0;
        stall = 0;
        seen  = 1'b0;
        repeat (30) begin
            if (!seen && b.out_valid) begin
                seen  = 1'b1;
                stall = 5;
            end
            b.out_ready = (stall == 0);
            b.in_valid  = (idx < 6);
            b.data_in   = 8'(idx + 1);
            b.mode      = 3'd0;
            b.smt       = 3'd1;
            @(negedge clk);
            if (stall > 0) begin
                chk(32'(b.in_ready), 32'd0, "bp_in_ready_full");
                chk(32'(b.data_out), 32'h02, "bp_data_held");
                stall--;
            end
            acc = b.in_valid && b.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        b.in_valid = 1'b0;
        chk(32'(n_out - n0), 32'd6, "bp_beat_count");
        for (int i = 0; i < 6; i++) begin
            if (i < obs_q.size())
                chk(32'(obs_q[i]), 32'(2 * (i + 1)), "bp_order");
        end

        // Reset with three beats in flight.
        b.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b.in_valid = 1'b1;
            b.data_in  = 8'(8'h10 + i);
            b.mode     = 3'd0;
            b.smt      = 3'd0;
            @(posedge clk); #1;
        end
        b.out_ready = 1'b0;
        b.data_in   = 8'h77;
        rst         = 1'b1;
        @(posedge clk); #1;
        chk(32'(b.out_valid), 32'd0, "flush_out_valid");
        chk(32'(b.in_ready), 32'd1, "flush_in_ready");
        chk(32'(b.data_out), 32'd0, "flush_data_out");
        rst         = 1'b0;
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        n0          = n_out;
        repeat (6) begin
            @(posedge clk); #1;
            chk(32'(b.out_valid), 32'd0, "flush_stays_empty");
        end
        chk(32'(n_out - n0), 32'd0, "flush_no_beats");
        send_check(3'd5, 8'h01, 3'd1, 8'h80, 1'b1, 1'b0, "post_flush");

        // Randomized stream with random backpressure.
        repeat (400) begin
            b.in_valid  = ($urandom_range(0, 3) != 0);
            b.out_ready = ($urandom_range(0, 2) != 0);
            b.data_in   = 8'($urandom);
            b.smt       = 3'($urandom);
            b.mode      = 3'($urandom);
            @(posedge clk); #1;
        end
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk(32'(exp_d.size()), 32'd0, "drain_empty");
        chk(32'(b.out_valid), 32'd0, "drain_out_valid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
